// File: rtl/rst_ce_seq_pkg.sv
// rst_ce_seq_pkg: shared state encoding and default widths for the rst/ce sequencer
package rst_ce_seq_pkg;
  localparam int RST_W_DEF = 4;
  localparam int GAP_W_DEF = 4;
  localparam int CE_W_DEF  = 8;
  typedef enum logic [1:0] {IDLE, RST, GAP, CE} seq_state_t;
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down-counter that stops at zero and flags it
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= din;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/rst_ce_sequencer.sv
// rst_ce_sequencer: drives a reset window, optional gap, then a clock-enable window on start
// Define SEQ_OVERLAP_EN to advance the CE window by one cycle (overlaps the last rst cycle when gap=0).
module rst_ce_sequencer
  import rst_ce_seq_pkg::*;
#(
  parameter int RST_W = RST_W_DEF,
  parameter int GAP_W = GAP_W_DEF,
  parameter int CE_W  = CE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [RST_W-1:0] rst_len_i,
  input  logic [GAP_W-1:0] gap_len_i,
  input  logic [CE_W-1:0]  ce_len_i,
  output logic             dut_rst_o,
  output logic             dut_ce_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             start_drop_o
);
`ifdef SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  seq_state_t state, nxt;
  logic [GAP_W-1:0] glen;
  logic [CE_W-1:0] clen;
  logic [RST_W-1:0] rl;
  logic idle, acc, ovl_in, ovl, skip_r, gskip, rz, gz, cz;
  assign idle   = state == IDLE;
  assign acc    = idle && start_i && !abort_i;
  assign rl     = rst_len_i == '0 ? RST_W'(1) : rst_len_i;
  // Overlap with no gap: RST is one cycle shorter and its last cycle becomes the first CE cycle
  assign ovl_in = OVL && gap_len_i == '0;
  assign skip_r = ovl_in && rl == RST_W'(1);
  assign ovl    = idle ? ovl_in : OVL && glen == '0;
  assign gskip  = OVL ? glen <= GAP_W'(1) : glen == '0;
  seq_down_counter #(.W(RST_W)) u_rc (
    .clk(clk), .rst(rst), .load(acc), .en(state == RST),
    .din(rl - RST_W'(ovl_in ? 2 : 1)), .zero(rz)
  );
  seq_down_counter #(.W(GAP_W)) u_gc (
    .clk(clk), .rst(rst), .load(acc), .en(state == GAP),
    .din(gap_len_i - GAP_W'(OVL ? 2 : 1)), .zero(gz)
  );
  seq_down_counter #(.W(CE_W)) u_cc (
    .clk(clk), .rst(rst), .load(acc), .en(state == CE),
    .din(ce_len_i - CE_W'(1)), .zero(cz)
  );
  always_comb begin
    nxt = (!idle && abort_i) ? IDLE :
          idle               ? (acc ? (skip_r ? CE : RST) : IDLE) :
          state == RST       ? (rz ? (gskip ? CE : GAP) : RST) :
          state == GAP       ? (gz ? CE : GAP) :
          (clen != '0 && cz) ? IDLE : CE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      glen         <= '0;
      clen         <= '0;
      dut_rst_o    <= 1'b0;
      dut_ce_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
      start_drop_o <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        glen <= gap_len_i;
        clen <= ce_len_i;
      end
      dut_rst_o    <= nxt == RST || (ovl && nxt == CE && state != CE);
      dut_ce_o     <= nxt == CE;
      busy_o       <= nxt != IDLE;
      done_o       <= state == CE && nxt == IDLE && !abort_i;
      aborted_o    <= abort_i && !idle;
      start_drop_o <= start_i && (!idle || abort_i);
    end
  end
endmodule

// File: tb/tb_rst_ce_sequencer.sv
// tb_rst_ce_sequencer: window-arithmetic reference model feeding a per-cycle scoreboard
module tb_rst_ce_sequencer;
`ifdef SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start_i, abort_i;
  logic [3:0] rst_len_i, gap_len_i;
  logic [7:0] ce_len_i;
  logic dut_rst_o, dut_ce_o, busy_o, done_o, aborted_o, start_drop_o;
  typedef struct packed {logic r; logic c; logic b; logic d; logic a; logic s;} exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  int k = 0, mcyc = 0;
  bit active = 0;
  int t0 = 0, rr = 0, gg = 0, cc = 0;

  always #5 clk = ~clk;

  rst_ce_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .rst_len_i(rst_len_i), .gap_len_i(gap_len_i), .ce_len_i(ce_len_i),
    .dut_rst_o(dut_rst_o), .dut_ce_o(dut_ce_o), .busy_o(busy_o),
    .done_o(done_o), .aborted_o(aborted_o), .start_drop_o(start_drop_o)
  );

  // Sequence occupies cycles t0+1 .. cs+cc-1; cs is the first CE cycle, cs+cc the done cycle
  task automatic step(input bit r, input bit s, input bit a, input int rl, input int gl, input int cl);
    exp_t e;
    bit bn;
    int cs, n;
    rst = r; start_i = s; abort_i = a;
    rst_len_i = 4'(rl); gap_len_i = 4'(gl); ce_len_i = 8'(cl);
    e = '0;
    cs = OVL ? t0 + rr + gg : t0 + rr + gg + 1;
    bn = active && (cc == 0 || k < cs + cc);
    if (r) active = 0;
    else begin
      if (!bn) active = 0;
      if (a && bn) begin
        active = 0;
        e.a = 1;
      end
      e.s = s && (bn || a);
      if (s && !bn && !a) begin
        active = 1; t0 = k; rr = (rl == 0) ? 1 : rl; gg = gl; cc = cl;
      end
      n = k + 1;
      cs = OVL ? t0 + rr + gg : t0 + rr + gg + 1;
      if (active) begin
        e.r = n <= t0 + rr;
        e.c = n >= cs && (cc == 0 || n < cs + cc);
        e.d = cc != 0 && n == cs + cc;
        e.b = cc == 0 || n < cs + cc;
      end
    end
    @(posedge clk);
    q.push_back(e);
    k++;
    #1;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) step(0, 0, 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
  endtask

  always @(negedge clk) begin
    exp_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {dut_rst_o, dut_ce_o, busy_o, done_o, aborted_o, start_drop_o};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL outputs cycle %0d: got rst=%b ce=%b busy=%b done=%b abrt=%b drop=%b, expected rst=%b ce=%b busy=%b done=%b abrt=%b drop=%b",
                 mcyc, g.r, g.c, g.b, g.d, g.a, g.s, e.r, e.c, e.b, e.d, e.a, e.s);
      end
    end
    mcyc++;
  end

  initial begin
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0, 2); idle(6);
    step(0, 1, 0, 2, 3, 1); idle(8);
    step(0, 1, 0, 2, 0, 0); idle(6); step(0, 0, 1, 0, 0, 0); idle(3);
    step(0, 1, 0, 2, 0, 2); idle(1); step(0, 1, 0, 9, 9, 9); idle(5);
    step(0, 1, 0, 0, 1, 3); idle(7);
    step(0, 1, 1, 2, 0, 2); step(0, 0, 1, 0, 0, 0); idle(2);
    step(0, 1, 0, 3, 0, 2); idle(1); step(1, 0, 0, 0, 0, 0); idle(1);
    step(0, 1, 0, 2, 0, 2); idle(7);
    repeat (10) step(0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 4) == 0, ($urandom % 25) == 0,
           $urandom_range(0, 15), ($urandom % 2) ? 0 : $urandom_range(0, 15),
           ($urandom % 8) == 0 ? 0 : $urandom_range(1, 12));
    end
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
